// File: rtl/shift_reg_sequencer.sv
// Command-driven controller for one universal shift register: LOAD / SHL / SHR / READ with a result strobe.
// Define SEQ_ABORT_EN to add an `abort` input that cuts a LOAD/SHIFT short and reports partial contents.
module shift_reg_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
`ifdef SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             sr_enable,
    output logic             sr_parallel_load,
    output logic             sr_shift_left,
    output logic             sr_shift_right,
    output logic [WIDTH-1:0] sr_data_in,
    input  logic [WIDTH-1:0] sr_data_out,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dir_left_reg, dir_left_next;
    logic             cmd_ready_reg, cmd_ready_next;
    logic             busy_reg, busy_next;
    logic             sr_enable_reg, sr_enable_next;
    logic             sr_load_reg, sr_load_next;
    logic             sr_left_reg, sr_left_next;
    logic             sr_right_reg, sr_right_next;
    logic [WIDTH-1:0] sr_data_in_reg, sr_data_in_next;
    logic             res_valid_reg, res_valid_next;
    logic [WIDTH-1:0] res_data_reg, res_data_next;
    logic             abort_req;

`ifdef SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Next-state logic; every output is then decoded from state_next so it is registered (Moore).
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        dir_left_next   = dir_left_reg;
        sr_data_in_next = sr_data_in_reg;
        res_data_next   = res_data_reg;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            state_next      = S_LOAD;
                            sr_data_in_next = cmd_data;
                        end
                        OP_SHL, OP_SHR: begin
                            dir_left_next = (cmd_op == OP_SHL);
                            if (cmd_count != '0) begin
                                state_next = S_SHIFT;
                                cnt_next   = cmd_count;
                            end else begin
                                state_next = S_DONE;
                            end
                        end
                        default: state_next = S_DONE;
                    endcase
                end
            end
            S_LOAD: state_next = S_SETTLE;
            S_SHIFT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (abort_req || cnt_reg == CNT_W'(1)) begin
                    state_next = S_SETTLE;
                    cnt_next   = '0;
                end
            end
            S_SETTLE: state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase

        // DONE is only ever entered for a single cycle, so capture on entry.
        if (state_next == S_DONE) begin
            res_data_next = sr_data_out;
        end

        cmd_ready_next = (state_next == S_IDLE);
        busy_next      = (state_next != S_IDLE);
        sr_load_next   = (state_next == S_LOAD);
        sr_left_next   = (state_next == S_SHIFT) && dir_left_next;
        sr_right_next  = (state_next == S_SHIFT) && !dir_left_next;
        sr_enable_next = sr_load_next || (state_next == S_SHIFT);
        res_valid_next = (state_next == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            dir_left_reg   <= 1'b0;
            cmd_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            sr_enable_reg  <= 1'b0;
            sr_load_reg    <= 1'b0;
            sr_left_reg    <= 1'b0;
            sr_right_reg   <= 1'b0;
            sr_data_in_reg <= '0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            dir_left_reg   <= dir_left_next;
            cmd_ready_reg  <= cmd_ready_next;
            busy_reg       <= busy_next;
            sr_enable_reg  <= sr_enable_next;
            sr_load_reg    <= sr_load_next;
            sr_left_reg    <= sr_left_next;
            sr_right_reg   <= sr_right_next;
            sr_data_in_reg <= sr_data_in_next;
            res_valid_reg  <= res_valid_next;
            res_data_reg   <= res_data_next;
        end
    end

    assign cmd_ready        = cmd_ready_reg;
    assign busy             = busy_reg;
    assign sr_enable        = sr_enable_reg;
    assign sr_parallel_load = sr_load_reg;
    assign sr_shift_left    = sr_left_reg;
    assign sr_shift_right   = sr_right_reg;
    assign sr_data_in       = sr_data_in_reg;
    assign res_valid        = res_valid_reg;
    assign res_data         = res_data_reg;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Self-checking bench for shift_reg_sequencer driving a behavioural universal shift register.
// Define SEQ_ABORT_EN to also exercise the abort path.
module tb_shift_reg_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             sr_enable;
    logic             sr_parallel_load;
    logic             sr_shift_left;
    logic             sr_shift_right;
    logic [WIDTH-1:0] sr_data_in;
    logic [WIDTH-1:0] sr_data_out;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             busy;
`ifdef SEQ_ABORT_EN
    logic             abort;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] model_val;
    logic [WIDTH-1:0] last_load = '0;

    always #5 clk = ~clk;

    shift_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_count        (cmd_count),
        .cmd_data         (cmd_data),
`ifdef SEQ_ABORT_EN
        .abort            (abort),
`endif
        .sr_enable        (sr_enable),
        .sr_parallel_load (sr_parallel_load),
        .sr_shift_left    (sr_shift_left),
        .sr_shift_right   (sr_shift_right),
        .sr_data_in       (sr_data_in),
        .sr_data_out      (sr_data_out),
        .res_valid        (res_valid),
        .res_data         (res_data),
        .busy             (busy)
    );

    // The register being sequenced: zero-filling shifts, registered output.
    logic [WIDTH-1:0] sr_q = '0;
    assign sr_data_out = sr_q;
    always @(posedge clk) begin
        if (sr_enable) begin
            if (sr_parallel_load)    sr_q <= sr_data_in;
            else if (sr_shift_left)  sr_q <= {sr_q[WIDTH-2:0], 1'b0};
            else if (sr_shift_right) sr_q <= {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    function automatic int exp_latency(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
        if (op == 2'b00) return 3;
        if (op == 2'b11 || cnt == 0) return 1;
        return int'(cnt) + 2;
    endfunction

    function automatic logic [WIDTH-1:0] exp_value(input logic [WIDTH-1:0] cur, input logic [1:0] op,
                                                  input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] data);
        case (op)
            2'b00:   return data;
            2'b01:   return cur << cnt;
            2'b10:   return cur >> cnt;
            default: return cur;
        endcase
    endfunction

    // Issues one command and reports what was observed until its result strobe.
    task automatic run_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] data,
                           output int lat, output int n_pl, output int n_sl, output int n_sr, output int n_bad,
                           output logic rdy_after, output logic [WIDTH-1:0] rdata, output logic strobe_once);
        int guard = 0;
        logic [WIDTH-1:0] hold_val;
        hold_val = (op == 2'b00) ? data : last_load;
        lat = 0; n_pl = 0; n_sl = 0; n_sr = 0; n_bad = 0; rdy_after = 1'b1; rdata = '0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_data = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_count = CNT_W'($urandom);
        cmd_data  = WIDTH'($urandom);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) rdy_after = cmd_ready;
            if (sr_parallel_load) n_pl++;
            if (sr_shift_left)    n_sl++;
            if (sr_shift_right)   n_sr++;
            if ((int'(sr_parallel_load) + int'(sr_shift_left) + int'(sr_shift_right)) > 1) n_bad++;
            if (!sr_enable && (sr_parallel_load || sr_shift_left || sr_shift_right)) n_bad++;
            if (!sr_parallel_load && sr_data_in !== hold_val) n_bad++;
            if (res_valid) begin
                lat   = cyc;
                rdata = res_data;
                break;
            end
        end
        @(negedge clk);
        strobe_once = !res_valid && cmd_ready && !busy;
        last_load = hold_val;
        $display("txn op=%0d cnt=%0d data=%02h res=%02h lat=%0d pl=%0d sl=%0d sr=%0d",
                 op, cnt, data, rdata, lat, n_pl, n_sl, n_sr);
    endtask

    task automatic test_reset_state;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (res_valid !== 1'b0 || res_data !== '0) begin
            errors++; $display("FAIL reset_res got=%b/%02h exp=0/00", res_valid, res_data); end
        checks++; if ({sr_enable, sr_parallel_load, sr_shift_left, sr_shift_right} !== 4'b0 || sr_data_in !== '0) begin
            errors++; $display("FAIL reset_sr got=%b%b%b%b/%02h exp=0000/00", sr_enable, sr_parallel_load,
                               sr_shift_left, sr_shift_right, sr_data_in); end
    endtask

    task automatic test_load;
        int lat, npl, nsl, nsr, nbad; logic rdy, once; logic [WIDTH-1:0] rd;
        run_cmd(2'b00, 4'd0, 8'hAA, lat, npl, nsl, nsr, nbad, rdy, rd, once);
        model_val = 8'hAA;
        checks++; if (npl != 1 || nsl != 0 || nsr != 0) begin
            errors++; $display("FAIL load_pulses got=%0d/%0d/%0d exp=1/0/0", npl, nsl, nsr); end
        checks++; if (lat != 3) begin errors++; $display("FAIL load_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 8'hAA) begin errors++; $display("FAIL load_data got=%02h exp=aa", rd); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL load_ready_drop got=%b exp=0", rdy); end
        checks++; if (once !== 1'b1) begin errors++; $display("FAIL load_strobe_once got=%b exp=1", once); end
        checks++; if (nbad != 0) begin errors++; $display("FAIL load_ctrl_rules got=%0d exp=0", nbad); end
    endtask

    task automatic test_reset_mid;
        int res_seen = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 4'd10; cmd_data = 8'h00;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sr_shift_left !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_shift_active got=%b/%b exp=1/1", sr_shift_left, busy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({sr_enable, sr_parallel_load, sr_shift_left, sr_shift_right, busy, res_valid} !== 6'b0
                      || res_data !== '0 || sr_data_in !== '0) begin
            errors++; $display("FAIL async_reset_outputs got=%b%b%b%b%b%b/%02h/%02h exp=000000/00/00", sr_enable,
                               sr_parallel_load, sr_shift_left, sr_shift_right, busy, res_valid, res_data, sr_data_in); end
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        last_load = '0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_ready got=%b/%b exp=1/0", cmd_ready, busy); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (res_valid) res_seen++;
        end
        checks++; if (res_seen != 0) begin errors++; $display("FAIL abandoned_cmd_strobe got=%0d exp=0", res_seen); end
    endtask

    task automatic test_shift_left;
        int lat, npl, nsl, nsr, nbad; logic rdy, once; logic [WIDTH-1:0] rd;
        run_cmd(2'b00, 4'd0, 8'h81, lat, npl, nsl, nsr, nbad, rdy, rd, once);
        run_cmd(2'b01, 4'd3, 8'h00, lat, npl, nsl, nsr, nbad, rdy, rd, once);
        checks++; if (nsl != 3 || nsr != 0 || npl != 0) begin
            errors++; $display("FAIL shl3_pulses got=%0d/%0d/%0d exp=3/0/0", nsl, nsr, npl); end
        checks++; if (rd !== 8'h08) begin errors++; $display("FAIL shl3_data got=%02h exp=08", rd); end
        checks++; if (lat != 5) begin errors++; $display("FAIL shl3_latency got=%0d exp=5", lat); end
        checks++; if (nbad != 0) begin errors++; $display("FAIL shl3_ctrl_rules got=%0d exp=0", nbad); end
    endtask

    task automatic test_zero_count;
        int lat, npl, nsl, nsr, nbad; logic rdy, once; logic [WIDTH-1:0] rd;
        run_cmd(2'b00, 4'd0, 8'hF0, lat, npl, nsl, nsr, nbad, rdy, rd, once);
        run_cmd(2'b10, 4'd0, 8'h00, lat, npl, nsl, nsr, nbad, rdy, rd, once);
        checks++; if (npl + nsl + nsr != 0) begin errors++; $display("FAIL shr0_pulses got=%0d exp=0", npl + nsl + nsr); end
        checks++; if (lat != 1) begin errors++; $display("FAIL shr0_latency got=%0d exp=1", lat); end
        checks++; if (rd !== 8'hF0) begin errors++; $display("FAIL shr0_data got=%02h exp=f0", rd); end
        run_cmd(2'b11, 4'd7, 8'h12, lat, npl, nsl, nsr, nbad, rdy, rd, once);
        checks++; if (lat != 1 || rd !== 8'hF0 || nbad != 0) begin
            errors++; $display("FAIL read_result got=%0d/%02h/%0d exp=1/f0/0", lat, rd, nbad); end
    endtask

    task automatic test_max_count;
        int lat, npl, nsl, nsr, nbad; logic rdy, once; logic [WIDTH-1:0] rd;
        run_cmd(2'b00, 4'd0, 8'hFF, lat, npl, nsl, nsr, nbad, rdy, rd, once);
        run_cmd(2'b10, 4'd15, 8'h00, lat, npl, nsl, nsr, nbad, rdy, rd, once);
        checks++; if (nsr != 15 || nsl != 0) begin errors++; $display("FAIL shr15_pulses got=%0d/%0d exp=15/0", nsr, nsl); end
        checks++; if (lat != 17 || rd !== 8'h00) begin
            errors++; $display("FAIL shr15_result got=%0d/%02h exp=17/00", lat, rd); end
    endtask

    task automatic test_back_to_back;
        int lat1 = 0, lat2 = 0, sl1 = 0, sl2 = 0;
        logic [WIDTH-1:0] rd1 = '0, rd2 = '0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_count = 4'd0; cmd_data = 8'h3C;
        @(posedge clk);
        #1;
        cmd_op = 2'b01; cmd_count = 4'd2; cmd_data = 8'h55;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (sr_shift_left) sl1++;
            if (res_valid) begin lat1 = cyc; rd1 = res_data; break; end
        end
        checks++; if (lat1 != 3 || rd1 !== 8'h3C || sl1 != 0) begin
            errors++; $display("FAIL b2b_first got=%0d/%02h/%0d exp=3/3c/0", lat1, rd1, sl1); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_ready_after_strobe got=%b/%b exp=1/0", cmd_ready, busy); end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (sr_shift_left) sl2++;
            if (res_valid) begin lat2 = cyc; rd2 = res_data; break; end
        end
        checks++; if (lat2 != 4 || rd2 !== 8'hF0 || sl2 != 2) begin
            errors++; $display("FAIL b2b_second got=%0d/%02h/%0d exp=4/f0/2", lat2, rd2, sl2); end
        checks++; if (sr_data_in !== 8'h3C) begin errors++; $display("FAIL b2b_data_in_hold got=%02h exp=3c", sr_data_in); end
        last_load = 8'h3C;
        $display("txn b2b load=3c shl2 res1=%02h res2=%02h lat1=%0d lat2=%0d", rd1, rd2, lat1, lat2);
    endtask

    task automatic test_random;
        int lat, npl, nsl, nsr, nbad; logic rdy, once; logic [WIDTH-1:0] rd, expv;
        logic [1:0] op; logic [CNT_W-1:0] cnt; logic [WIDTH-1:0] data;
        model_val = 'x;
        for (int t = 0; t < 40; t++) begin
            op   = (t == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            cnt  = ($urandom_range(0, 5) == 0) ? CNT_W'(0) : CNT_W'($urandom);
            data = WIDTH'($urandom);
            expv = exp_value(model_val, op, cnt, data);
            run_cmd(op, cnt, data, lat, npl, nsl, nsr, nbad, rdy, rd, once);
            checks++; if (rd !== expv) begin errors++; $display("FAIL rnd_data t=%0d got=%02h exp=%02h", t, rd, expv); end
            checks++; if (lat != exp_latency(op, cnt)) begin
                errors++; $display("FAIL rnd_latency t=%0d got=%0d exp=%0d", t, lat, exp_latency(op, cnt)); end
            checks++; if (npl != (op == 2'b00 ? 1 : 0) || nsl != (op == 2'b01 ? int'(cnt) : 0)
                          || nsr != (op == 2'b10 ? int'(cnt) : 0)) begin
                errors++; $display("FAIL rnd_pulses t=%0d got=%0d/%0d/%0d", t, npl, nsl, nsr); end
            checks++; if (nbad != 0 || rdy !== 1'b0 || once !== 1'b1) begin
                errors++; $display("FAIL rnd_protocol t=%0d got=%0d/%b/%b exp=0/0/1", t, nbad, rdy, once); end
            model_val = expv;
        end
    endtask

`ifdef SEQ_ABORT_EN
    task automatic test_abort;
        int lat, npl, nsl, nsr, nbad; logic rdy, once; logic [WIDTH-1:0] rd;
        int nshift = 0, rv_cyc = 0, idle_cyc = 0;
        run_cmd(2'b00, 4'd0, 8'hFF, lat, npl, nsl, nsr, nbad, rdy, rd, once);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 4'd15; cmd_data = 8'h00;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (sr_shift_right) nshift++;
            abort = (cyc == 2);
            if (res_valid) begin rv_cyc = cyc; rd = res_data; end
            if (!busy && idle_cyc == 0) idle_cyc = cyc;
        end
        abort = 1'b0;
        checks++; if (nshift != 2 || rd !== 8'h3F) begin
            errors++; $display("FAIL abort_result got=%0d/%02h exp=2/3f", nshift, rd); end
        checks++; if (rv_cyc != 4 || idle_cyc != 5) begin
            errors++; $display("FAIL abort_timing got=%0d/%0d exp=4/5", rv_cyc, idle_cyc); end
        $display("txn abort shr15 res=%02h shifts=%0d", rd, nshift);
    endtask
`endif

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0; cmd_data = '0;
`ifdef SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        test_reset_state;
        test_load;
        test_reset_mid;
        test_shift_left;
        test_zero_count;
        test_max_count;
        test_back_to_back;
        test_random;
`ifdef SEQ_ABORT_EN
        test_abort;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
